ahb_arbiter: RTL and testbench
==============================

# ahb_arbiter

Burst-aware round-robin arbiter for the multi-master AHB interconnect. It grants the shared address/control bus to one of `NO_OF_MASTERS` requesters and drives `HMASTER` to select the master mux. It keeps ownership through fixed-length bursts and locked sequences, and parks the bus on master 0 when no master is requesting.

## Interface
- `NO_OF_MASTERS`, default `ahb_params_pkg::NO_OF_MASTERS` (2): number of requesting masters, range 2..16.
- `MW`, default `$clog2(NO_OF_MASTERS)`: width of `HMASTER`. Derived; not overridden.
- `HCLK` input 1: bus clock. All state changes on its rising edge.
- `HRESETn` input 1: reset. Asynchronous, active-low.
- `HBUSREQ` input `NO_OF_MASTERS`: per-master bus request.
- `HLOCK` input `NO_OF_MASTERS`: per-master locked-transfer request.
- `HTRANS` input 2: transfer type of the current address-phase owner, already muxed by `HMASTER`.
- `HBURST` input 3: burst type of the current address-phase owner.
- `HREADY` input 1: bus-wide ready. 1 means the current address phase is accepted this cycle.
- `HGRANT` output `NO_OF_MASTERS`: one-hot grant. Registered.
- `HMASTER` output `MW`: index of the master that owns the address phase. Registered.
- `HMASTLOCK` output 1: the current owner's transfer is locked. Registered.

## Operation
- Reset values:
  - `HGRANT` = one-hot bit 0.
  - `HMASTER` = 0.
  - `HMASTLOCK` = 0.
  - State = `ARB`.
  - `beats_left` = 0.
  - `rr_ptr` = 0.
- All sequential updates, except reset, are qualified by `HREADY=1`. When `HREADY=0`, every register holds.
- States:
  - `ARB`: rearbitration is allowed on every ready edge.
  - `BURST`: a fixed-length burst is in progress.
  - `LOCKED`: the owner holds `HLOCK`.
- Burst length comes from `HBURST`:
  - `WRAP4`/`INCR4` = 4 beats.
  - `WRAP8`/`INCR8` = 8 beats.
  - `WRAP16`/`INCR16` = 16 beats.
  - `SINGLE` and `INCR` are not fixed; they never enter `BURST`.
- `ARB` -> `BURST`: on a ready edge with `HTRANS=NONSEQ` and a fixed `HBURST`. Load `beats_left` = length-1.
- In `BURST`:
  - `HTRANS=SEQ` with `HREADY=1` decrements `beats_left`.
  - `BUSY` holds `beats_left`.
  - `IDLE` or `NONSEQ` is an early termination: go to `ARB` and rearbitrate on that same edge.
- `BURST` -> `ARB`: on the ready edge where `beats_left==1` and `HTRANS=SEQ`, i.e. the final beat is accepted. Rearbitration happens on that same edge.
- Winner selection:
  - Round-robin over `HBUSREQ`, starting at index `rr_ptr+1` mod N.
  - On a grant, `rr_ptr` takes the winner index.
  - If no requests are pending, grant master 0 (default master) and leave `rr_ptr` unchanged.
- Rearbitration edge (ready edge while in `ARB`, or as described above): `HGRANT` is loaded with the one-hot winner.
- `HMASTER` is loaded with `encode(HGRANT)` on every ready edge, so it lags `HGRANT` by exactly one ready edge.
- `HMASTLOCK` is loaded with `HLOCK[encode(HGRANT)] & HBUSREQ[encode(HGRANT)]` on the same edge as `HMASTER`.
- Lock handling:
  - If the granted master has `HLOCK=1` when `HMASTER` updates, enter `LOCKED`.
  - `LOCKED` has priority over `BURST`: the grant does not change while `HLOCK[HMASTER]=1`.
  - When `HLOCK` drops, go to `BURST` if `beats_left>0`, otherwise to `ARB`.
- `beats_left` is 4 bits, saturating at 0. It never underflows on stray `SEQ`.
- Asynchronous reset in any state, including mid-burst or while locked, restores the reset values immediately.

## Timing
- Request to grant: a request sampled in `ARB` on ready edge *t* is reflected in `HGRANT` after edge *t*, a latency of 1 cycle.
- Grant to `HMASTER`: `HMASTER` follows on the next ready edge. The newly granted master drives its first address in the cycle after `HMASTER` changes.
- Wait states stretch both latencies one-for-one.
- `HGRANT` always has exactly one bit set, including in reset. It is never all-zero.
- Simultaneous requests with `rr_ptr=0` and N=2: master 1 wins first.

## Structure
- Add the following to `ahb_params_pkg`:
  - `typedef enum logic [1:0] {ARB, BURST, LOCKED} arb_state_t`.
  - `function automatic int burst_beats(logic [2:0] hburst)`, returning 1 for `SINGLE`/`INCR`, otherwise 4, 8 or 16.
- The existing `HTRANS`/`HBURST` encodings in `ahb_params_pkg` are reused unchanged.
- Sub-module `ahb_rr_picker`: combinational.
  - Inputs: `req[N]`, `ptr`.
  - Outputs: one-hot `gnt`, `valid`.
  - Instantiated once.

## Test plan
- Reset: `HRESETn=0` with arbitrary inputs -> `HGRANT=01`, `HMASTER=0`, `HMASTLOCK=0`. These values hold for 2 cycles after release with no requests.
- Fairness: N=2, `HBUSREQ=11`, `HTRANS=NONSEQ`, `HBURST=SINGLE`, `HREADY=1` -> `HGRANT` sequence 10, 01, 10, 01 on consecutive edges. `HMASTER` follows one edge later.
- Fixed burst: M0 owner issues `INCR4` (NONSEQ, SEQ, SEQ, SEQ) while `HBUSREQ[1]=1` -> `HGRANT` stays 01 until the edge accepting the 3rd `SEQ`, then becomes 10.
- Wait states: insert `HREADY=0` for 3 cycles mid-`WRAP8` -> `beats_left`, `HGRANT` and `HMASTER` are frozen. The handover occurs only after all 8 beats.
- Lock: M1 asserts `HBUSREQ=1` and `HLOCK=1` -> `HMASTLOCK=1` one ready edge after the grant, and M0 is not granted until `HLOCK[1]` falls. M0 is then granted on the next ready edge.
- Early termination/reset: M0 drives `IDLE` after 2 beats of `INCR16` -> M1 is granted on that edge. A separate run asserts `HRESETn=0` mid-burst -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ahb_params_pkg.sv
// Shared AHB encodings and arbiter types for the multi-master interconnect.
package ahb_params_pkg;

   localparam int NO_OF_MASTERS = 2;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'd0;
   localparam logic [2:0] HBURST_INCR   = 3'd1;
   localparam logic [2:0] HBURST_WRAP4  = 3'd2;
   localparam logic [2:0] HBURST_INCR4  = 3'd3;
   localparam logic [2:0] HBURST_WRAP8  = 3'd4;
   localparam logic [2:0] HBURST_INCR8  = 3'd5;
   localparam logic [2:0] HBURST_WRAP16 = 3'd6;
   localparam logic [2:0] HBURST_INCR16 = 3'd7;

   typedef enum logic [1:0] {ARB, BURST, LOCKED} arb_state_t;

   // 1 marks an open-ended burst that never pins the grant.
   function automatic int burst_beats(logic [2:0] hburst);
      case (hburst)
         HBURST_WRAP4, HBURST_INCR4:   return 4;
         HBURST_WRAP8, HBURST_INCR8:   return 8;
         HBURST_WRAP16, HBURST_INCR16: return 16;
         default:                      return 1;
      endcase
   endfunction

endpackage

// File: rtl/ahb_arbiter_picker.sv
// Combinational round-robin picker: first requester after ptr wins.
module ahb_rr_picker #(
   parameter int N  = 2,
   parameter int MW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [MW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic          valid
);

   logic [MW:0] idx;

   always_comb begin
      gnt   = '0;
      valid = 1'b0;
      idx   = '0;
      for (int i = 1; i <= N; i++) begin
         idx = {1'b0, ptr} + (MW+1)'(i);
         if (idx >= (MW+1)'(N)) begin
            idx = idx - (MW+1)'(N);
         end
         if (!valid && req[idx[MW-1:0]]) begin
            gnt[idx[MW-1:0]] = 1'b1;
            valid            = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_arbiter.sv
// Burst- and lock-aware round-robin AHB arbiter with master-0 parking.
module ahb_arbiter
   import ahb_params_pkg::arb_state_t;
   import ahb_params_pkg::ARB;
   import ahb_params_pkg::BURST;
   import ahb_params_pkg::LOCKED;
   import ahb_params_pkg::burst_beats;
   import ahb_params_pkg::HTRANS_IDLE;
   import ahb_params_pkg::HTRANS_NONSEQ;
   import ahb_params_pkg::HTRANS_SEQ;
#(
   parameter int NO_OF_MASTERS = ahb_params_pkg::NO_OF_MASTERS,
   parameter int MW            = $clog2(NO_OF_MASTERS)
) (
   input  logic                     HCLK,
   input  logic                     HRESETn,
   input  logic [NO_OF_MASTERS-1:0] HBUSREQ,
   input  logic [NO_OF_MASTERS-1:0] HLOCK,
   input  logic [1:0]               HTRANS,
   input  logic [2:0]               HBURST,
   input  logic                     HREADY,
   output logic [NO_OF_MASTERS-1:0] HGRANT,
   output logic [MW-1:0]            HMASTER,
   output logic                     HMASTLOCK
);

   localparam int N = NO_OF_MASTERS;

   arb_state_t      state_q, state_d;
   logic [3:0]      beats_q, beats_d;
   logic [MW-1:0]   rr_q, rr_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic [MW-1:0]   mst_q, mst_d;
   logic            mlock_q, mlock_d;

   logic [N-1:0]    pick_gnt;
   logic            pick_vld;
   logic [MW-1:0]   gidx, pidx;
   logic            own_lock, fixed, seq, brk, rearb;
   int              nbeats;

   ahb_rr_picker #(
      .N  (N),
      .MW (MW)
   ) u_pick (
      .req   (HBUSREQ),
      .ptr   (rr_q),
      .gnt   (pick_gnt),
      .valid (pick_vld)
   );

   always_comb begin
      gidx = '0;
      pidx = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_q[i])    gidx = MW'(i);
         if (pick_gnt[i]) pidx = MW'(i);
      end
   end

   always_comb begin
      nbeats   = burst_beats(HBURST);
      own_lock = HLOCK[gidx] & HBUSREQ[gidx];
      fixed    = (HTRANS == HTRANS_NONSEQ) && (nbeats > 1);
      seq      = (HTRANS == HTRANS_SEQ);
      brk      = (HTRANS == HTRANS_IDLE) || (HTRANS == HTRANS_NONSEQ);
      rearb    = 1'b0;
      state_d  = state_q;
      beats_d  = beats_q;
      mst_d    = gidx;
      mlock_d  = own_lock;
      unique case (state_q)
         ARB: begin
            if (fixed) beats_d = 4'(nbeats - 1);
            if (own_lock)   state_d = LOCKED;
            else if (fixed) state_d = BURST;
            else            rearb   = 1'b1;
         end
         BURST: begin
            if (seq && beats_q != 4'd0) beats_d = beats_q - 4'd1;
            if (brk) beats_d = '0;
            if (own_lock) begin
               state_d = LOCKED;
            end else if (brk || beats_d == 4'd0) begin
               state_d = ARB;
               rearb   = 1'b1;
            end
         end
         LOCKED: begin
            // The locked owner may still run its own fixed bursts.
            if (fixed) begin
               beats_d = 4'(nbeats - 1);
            end else if (seq && beats_q != 4'd0) begin
               beats_d = beats_q - 4'd1;
            end
            if (!own_lock) begin
               if (beats_d != 4'd0) begin
                  state_d = BURST;
               end else begin
                  state_d = ARB;
                  rearb   = 1'b1;
               end
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_comb begin
      gnt_d = gnt_q;
      rr_d  = rr_q;
      if (rearb) begin
         if (pick_vld) begin
            gnt_d = pick_gnt;
            rr_d  = pidx;
         end else begin
            gnt_d = N'(1);
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ARB;
         beats_q <= '0;
         rr_q    <= '0;
         gnt_q   <= N'(1);
         mst_q   <= '0;
         mlock_q <= 1'b0;
      end else if (HREADY) begin
         state_q <= state_d;
         beats_q <= beats_d;
         rr_q    <= rr_d;
         gnt_q   <= gnt_d;
         mst_q   <= mst_d;
         mlock_q <= mlock_d;
      end
   end

   assign HGRANT    = gnt_q;
   assign HMASTER   = mst_q;
   assign HMASTLOCK = mlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scenario bench for ahb_arbiter with a per-edge expectation scoreboard.
module tb_ahb_arbiter;
   import ahb_params_pkg::*;

   logic       HCLK = 1'b0;
   logic       HRESETn;
   logic [1:0] HBUSREQ, HLOCK, HTRANS;
   logic [2:0] HBURST;
   logic       HREADY;
   logic [1:0] HGRANT;
   logic       HMASTER, HMASTLOCK;

   int n_run  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [1:0] g;
      logic       m;
      logic       l;
   } exp_t;

   typedef struct packed {
      logic [1:0] req;
      logic [1:0] lock;
      logic [1:0] trans;
      logic [2:0] burst;
      logic       rdy;
      logic [1:0] g;
      logic       m;
      logic       l;
   } step_t;

   exp_t sb[$];

   ahb_arbiter #(.NO_OF_MASTERS(2)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HBUSREQ   (HBUSREQ),
      .HLOCK     (HLOCK),
      .HTRANS    (HTRANS),
      .HBURST    (HBURST),
      .HREADY    (HREADY),
      .HGRANT    (HGRANT),
      .HMASTER   (HMASTER),
      .HMASTLOCK (HMASTLOCK)
   );

   initial forever #5 HCLK = ~HCLK;

   task automatic drive(input step_t s);
      HBUSREQ = s.req;
      HLOCK   = s.lock;
      HTRANS  = s.trans;
      HBURST  = s.burst;
      HREADY  = s.rdy;
      sb.push_back(exp_t'{s.g, s.m, s.l});
   endtask

   task automatic do_reset();
      HRESETn = 1'b0;
      HBUSREQ = 2'b00;
      HLOCK   = 2'b00;
      HTRANS  = HTRANS_IDLE;
      HBURST  = HBURST_SINGLE;
      HREADY  = 1'b1;
      sb.delete();
      repeat (2) @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
   endtask

   task automatic test_reset();
      step_t s [2];
      exp_t  e;
      HRESETn = 1'b0;
      HBUSREQ = 2'b11;
      HLOCK   = 2'b11;
      HTRANS  = HTRANS_NONSEQ;
      HBURST  = HBURST_INCR4;
      HREADY  = 1'b1;
      repeat (3) @(posedge HCLK);
      #1;
      n_run++;
      if ({HGRANT, HMASTER, HMASTLOCK} !== 4'b0100) begin
         n_fail++;
         $display("FAIL reset_hold: got %b%b%b expected 0100",
                  HGRANT, HMASTER, HMASTLOCK);
      end
      s[0] = '{2'b00, 2'b00, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 2'b01, 1'b0, 1'b0};
      s[1] = '{2'b00, 2'b00, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 2'b01, 1'b0, 1'b0};
      HRESETn = 1'b1;
      foreach (s[i]) begin
         drive(s[i]);
         @(posedge HCLK);
         #1;
         e = sb.pop_front();
         n_run++;
         if ({HGRANT, HMASTER, HMASTLOCK} !== e) begin
            n_fail++;
            $display("FAIL reset_release step %0d: got %b%b%b expected %b",
                     i, HGRANT, HMASTER, HMASTLOCK, e);
         end
      end
   endtask

   task automatic test_fairness();
      step_t s [4];
      exp_t  e;
      do_reset();
      s[0] = '{2'b11, 2'b00, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 2'b10, 1'b0, 1'b0};
      s[1] = '{2'b11, 2'b00, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 2'b01, 1'b1, 1'b0};
      s[2] = '{2'b11, 2'b00, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 2'b10, 1'b0, 1'b0};
      s[3] = '{2'b11, 2'b00, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 2'b01, 1'b1, 1'b0};
      foreach (s[i]) begin
         drive(s[i]);
         @(posedge HCLK);
         #1;
         e = sb.pop_front();
         n_run++;
         if ({HGRANT, HMASTER, HMASTLOCK} !== e) begin
            n_fail++;
            $display("FAIL fairness step %0d: got %b%b%b expected %b",
                     i, HGRANT, HMASTER, HMASTLOCK, e);
         end
      end
   endtask

   task automatic test_burst();
      step_t s [5];
      exp_t  e;
      do_reset();
      s[0] = '{2'b10, 2'b00, HTRANS_NONSEQ, HBURST_INCR4,  1'b1, 2'b01, 1'b0, 1'b0};
      s[1] = '{2'b10, 2'b00, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 2'b01, 1'b0, 1'b0};
      s[2] = '{2'b10, 2'b00, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 2'b01, 1'b0, 1'b0};
      s[3] = '{2'b10, 2'b00, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 2'b10, 1'b0, 1'b0};
      s[4] = '{2'b10, 2'b00, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 2'b10, 1'b1, 1'b0};
      foreach (s[i]) begin
         drive(s[i]);
         @(posedge HCLK);
         #1;
         e = sb.pop_front();
         n_run++;
         if ({HGRANT, HMASTER, HMASTLOCK} !== e) begin
            n_fail++;
            $display("FAIL burst_incr4 step %0d: got %b%b%b expected %b",
                     i, HGRANT, HMASTER, HMASTLOCK, e);
         end
      end
   endtask

   task automatic test_wait_states();
      step_t s [12];
      exp_t  e;
      do_reset();
      s[0] = '{2'b10, 2'b00, HTRANS_NONSEQ, HBURST_WRAP8, 1'b1, 2'b01, 1'b0, 1'b0};
      for (int k = 1; k <= 3; k++)
         s[k] = '{2'b10, 2'b00, HTRANS_SEQ, HBURST_WRAP8, 1'b1, 2'b01, 1'b0, 1'b0};
      for (int k = 4; k <= 6; k++)
         s[k] = '{2'b10, 2'b00, HTRANS_SEQ, HBURST_WRAP8, 1'b0, 2'b01, 1'b0, 1'b0};
      for (int k = 7; k <= 9; k++)
         s[k] = '{2'b10, 2'b00, HTRANS_SEQ, HBURST_WRAP8, 1'b1, 2'b01, 1'b0, 1'b0};
      s[10] = '{2'b10, 2'b00, HTRANS_SEQ,  HBURST_WRAP8,  1'b1, 2'b10, 1'b0, 1'b0};
      s[11] = '{2'b10, 2'b00, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 2'b10, 1'b1, 1'b0};
      foreach (s[i]) begin
         drive(s[i]);
         @(posedge HCLK);
         #1;
         e = sb.pop_front();
         n_run++;
         if ({HGRANT, HMASTER, HMASTLOCK} !== e) begin
            n_fail++;
            $display("FAIL wait_wrap8 step %0d: got %b%b%b expected %b",
                     i, HGRANT, HMASTER, HMASTLOCK, e);
         end
      end
   endtask

   task automatic test_lock();
      step_t s [7];
      exp_t  e;
      do_reset();
      s[0] = '{2'b11, 2'b10, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 2'b10, 1'b0, 1'b0};
      s[1] = '{2'b11, 2'b10, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 2'b10, 1'b1, 1'b1};
      s[2] = '{2'b11, 2'b10, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 2'b10, 1'b1, 1'b1};
      s[3] = '{2'b11, 2'b10, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 2'b10, 1'b1, 1'b1};
      s[4] = '{2'b11, 2'b00, HTRANS_IDLE, HBURST_SINGLE, 1'b0, 2'b10, 1'b1, 1'b1};
      s[5] = '{2'b11, 2'b00, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 2'b01, 1'b1, 1'b0};
      s[6] = '{2'b01, 2'b00, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 2'b01, 1'b0, 1'b0};
      foreach (s[i]) begin
         drive(s[i]);
         @(posedge HCLK);
         #1;
         e = sb.pop_front();
         n_run++;
         if ({HGRANT, HMASTER, HMASTLOCK} !== e) begin
            n_fail++;
            $display("FAIL lock step %0d: got %b%b%b expected %b",
                     i, HGRANT, HMASTER, HMASTLOCK, e);
         end
      end
   endtask

   task automatic test_early_term();
      step_t s [4];
      exp_t  e;
      do_reset();
      s[0] = '{2'b10, 2'b00, HTRANS_NONSEQ, HBURST_INCR16, 1'b1, 2'b01, 1'b0, 1'b0};
      s[1] = '{2'b10, 2'b00, HTRANS_SEQ,    HBURST_INCR16, 1'b1, 2'b01, 1'b0, 1'b0};
      s[2] = '{2'b10, 2'b00, HTRANS_IDLE,   HBURST_INCR16, 1'b1, 2'b10, 1'b0, 1'b0};
      s[3] = '{2'b10, 2'b00, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 2'b10, 1'b1, 1'b0};
      foreach (s[i]) begin
         drive(s[i]);
         @(posedge HCLK);
         #1;
         e = sb.pop_front();
         n_run++;
         if ({HGRANT, HMASTER, HMASTLOCK} !== e) begin
            n_fail++;
            $display("FAIL early_term step %0d: got %b%b%b expected %b",
                     i, HGRANT, HMASTER, HMASTLOCK, e);
         end
      end
   endtask

   task automatic test_async_reset();
      step_t s [3];
      step_t r [2];
      exp_t  e;
      do_reset();
      s[0] = '{2'b10, 2'b10, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 2'b10, 1'b0, 1'b0};
      s[1] = '{2'b10, 2'b10, HTRANS_NONSEQ, HBURST_INCR8,  1'b1, 2'b10, 1'b1, 1'b1};
      s[2] = '{2'b10, 2'b10, HTRANS_SEQ,    HBURST_INCR8,  1'b1, 2'b10, 1'b1, 1'b1};
      foreach (s[i]) begin
         drive(s[i]);
         @(posedge HCLK);
         #1;
         e = sb.pop_front();
         n_run++;
         if ({HGRANT, HMASTER, HMASTLOCK} !== e) begin
            n_fail++;
            $display("FAIL async_pre step %0d: got %b%b%b expected %b",
                     i, HGRANT, HMASTER, HMASTLOCK, e);
         end
      end
      HRESETn = 1'b0;
      #2;
      n_run++;
      if ({HGRANT, HMASTER, HMASTLOCK} !== 4'b0100) begin
         n_fail++;
         $display("FAIL async_reset: got %b%b%b expected 0100",
                  HGRANT, HMASTER, HMASTLOCK);
      end
      HBUSREQ = 2'b11;
      HLOCK   = 2'b00;
      HTRANS  = HTRANS_IDLE;
      HBURST  = HBURST_SINGLE;
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      r[0] = '{2'b11, 2'b00, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 2'b10, 1'b0, 1'b0};
      r[1] = '{2'b11, 2'b00, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 2'b01, 1'b1, 1'b0};
      foreach (r[i]) begin
         drive(r[i]);
         @(posedge HCLK);
         #1;
         e = sb.pop_front();
         n_run++;
         if ({HGRANT, HMASTER, HMASTLOCK} !== e) begin
            n_fail++;
            $display("FAIL async_post step %0d: got %b%b%b expected %b",
                     i, HGRANT, HMASTER, HMASTLOCK, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fairness();
      test_burst();
      test_wait_states();
      test_lock();
      test_early_term();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
